// File: rtl/latent_seq_ctrl.sv
// latent_seq_ctrl: runs a mu pass then a var pass per latent vector on the core and emits one packed record per vector
module latent_seq_ctrl #(
  parameter int          BEATS    = 8,
  parameter int          ADDR_W   = 19,
  parameter int          CNT_W    = 16,
  parameter logic [15:0] BIAS_MU  = 16'h0018,
  parameter logic [15:0] BIAS_VAR = 16'hFFFF,
  parameter int          TIMEOUT  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  num_vectors_i,
  output logic              busy_o,
  output logic              job_done_o,
  output logic              timeout_err_o,
  output logic              mem_rd_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [63:0]       mem_rdata_0_i,
  input  logic [63:0]       mem_rdata_1_i,
  input  logic [63:0]       mem_rdata_2_i,
  input  logic [63:0]       mem_rdata_3_i,
  output logic              core_rst_n_o,
  output logic              core_en_o,
  output logic              core_read_en_o,
  output logic              core_clr_o,
  output logic              core_op_mode_o,
  output logic [15:0]       core_bias_o,
  output logic [63:0]       dma_channel_0_o,
  output logic [63:0]       dma_channel_1_o,
  output logic [63:0]       dma_channel_2_o,
  output logic [63:0]       dma_channel_3_o,
  input  logic              core_done_i,
  input  logic [15:0]       core_result_i,
  input  logic [15:0]       core_pre_act_i,
  output logic [47:0]       out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i
);
  localparam int BW = $clog2(BEATS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, WAIT_HI, WAIT_LO, CAPTURE, EMIT} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] nvec_q, nvec_d, vec_q, vec_d;
  logic [BW-1:0] b_q, b_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic pass_q, pass_d, tmo_err_q, tmo_err_d, job_done_q, job_done_d, rd_q, expired, run;
  logic [15:0] mu_res_q, mu_pre_q, var_res_q, var_pre_q;
  logic [3:0][63:0] ch_q;
  assign expired = tmo_q == TW'(TIMEOUT - 1);
  always_comb begin
    state_d = state_q;
    nvec_d = nvec_q;
    vec_d = vec_q;
    pass_d = pass_q;
    b_d = b_q;
    tmo_d = '0;
    tmo_err_d = tmo_err_q;
    job_done_d = 1'b0;
    case (state_q)
      IDLE: if (start_i) begin
        tmo_err_d = 1'b0;
        if (num_vectors_i == '0) job_done_d = 1'b1;
        else begin
          state_d = CLEAR;
          nvec_d = num_vectors_i;
          vec_d = '0;
          pass_d = 1'b0;
        end
      end
      CLEAR: begin
        state_d = FEED;
        b_d = '0;
      end
      FEED: begin
        b_d = b_q + 1'b1;
        state_d = b_q == BW'(BEATS) ? WAIT_HI : FEED;
      end
      WAIT_HI, WAIT_LO: begin
        if ((state_q == WAIT_HI) == core_done_i) state_d = state_q == WAIT_HI ? WAIT_LO : CAPTURE;
        else if (expired) begin
          state_d = IDLE;
          pass_d = 1'b0;
          tmo_err_d = 1'b1;
          job_done_d = 1'b1;
        end else tmo_d = tmo_q + 1'b1;
      end
      CAPTURE: begin
        state_d = pass_q ? EMIT : CLEAR;
        pass_d = 1'b1;
      end
      EMIT: if (out_ready_i) begin
        pass_d = 1'b0;
        if (vec_q == nvec_q - CNT_W'(1)) begin
          state_d = IDLE;
          job_done_d = 1'b1;
        end else begin
          state_d = CLEAR;
          vec_d = vec_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      nvec_q <= '0;
      vec_q <= '0;
      b_q <= '0;
      tmo_q <= '0;
      pass_q <= 1'b0;
      tmo_err_q <= 1'b0;
      job_done_q <= 1'b0;
      rd_q <= 1'b0;
      ch_q <= '0;
      mu_res_q <= '0;
      mu_pre_q <= '0;
      var_res_q <= '0;
      var_pre_q <= '0;
    end else begin
      state_q <= state_d;
      nvec_q <= nvec_d;
      vec_q <= vec_d;
      b_q <= b_d;
      tmo_q <= tmo_d;
      pass_q <= pass_d;
      tmo_err_q <= tmo_err_d;
      job_done_q <= job_done_d;
      rd_q <= mem_rd_en_o;
      ch_q <= rd_q ? {mem_rdata_3_i, mem_rdata_2_i, mem_rdata_1_i, mem_rdata_0_i} : busy_o ? ch_q : '0;
      if (state_q == CAPTURE && !pass_q) {mu_res_q, mu_pre_q} <= {core_result_i, core_pre_act_i};
      if (state_q == CAPTURE && pass_q) {var_res_q, var_pre_q} <= {core_result_i, core_pre_act_i};
    end
  end
  assign run = state_q != IDLE && state_q != CLEAR;
  assign busy_o = state_q != IDLE;
  assign job_done_o = job_done_q;
  assign timeout_err_o = tmo_err_q;
  assign mem_rd_en_o = state_q == FEED && b_q < BW'(BEATS);
  assign mem_addr_o = mem_rd_en_o ? ADDR_W'(vec_q) * ADDR_W'(BEATS) + ADDR_W'(b_q) : '0;
  assign core_rst_n_o = run;
  assign core_clr_o = !run;
  assign core_en_o = (state_q == FEED && b_q != '0) || state_q == WAIT_HI || state_q == WAIT_LO || state_q == CAPTURE;
  assign core_read_en_o = core_en_o;
  assign core_op_mode_o = busy_o && pass_q;
  assign core_bias_o = !busy_o ? 16'h0 : pass_q ? BIAS_VAR : BIAS_MU;
  assign {dma_channel_3_o, dma_channel_2_o, dma_channel_1_o, dma_channel_0_o} = ch_q;
  assign out_valid_o = state_q == EMIT;
  assign out_data_o = out_valid_o ? {mu_res_q + var_res_q, mu_pre_q, var_pre_q} : '0;
endmodule

// File: tb/tb_latent_seq_ctrl.sv
// tb_latent_seq_ctrl: directed scenarios with a record scoreboard, buffer model and core model
module tb_latent_seq_ctrl;
  localparam int TIMEOUT = 1024;
  logic clk = 0, rst_n = 0, start = 0, out_ready = 1;
  logic [15:0] num_vectors = '0;
  logic busy, job_done, timeout_err, mem_rd_en, core_rst_n, core_en, core_read_en, core_clr, core_op_mode;
  logic [18:0] mem_addr;
  logic [63:0] rd0 = '0, rd1 = '0, rd2 = '0, rd3 = '0, dma0, dma1, dma2, dma3;
  logic [15:0] core_bias, core_result, core_pre_act;
  logic core_done, out_valid, stall = 0;
  logic [47:0] out_data, e_rec, held;
  logic [4:0] ccnt = '0;
  logic [15:0] mu_r = '0, mu_p = '0, var_r = '0, var_p = '0;
  logic [47:0] exp_q[$];
  int addr_log[$];
  logic [15:0] bias_log[$];
  int n_cmp = 0, n_err = 0, jd_cnt = 0, rec_cnt = 0, pa1 = -1, pa2 = -1;
  always #5 clk = ~clk;
  latent_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .num_vectors_i(num_vectors),
    .busy_o(busy), .job_done_o(job_done), .timeout_err_o(timeout_err),
    .mem_rd_en_o(mem_rd_en), .mem_addr_o(mem_addr),
    .mem_rdata_0_i(rd0), .mem_rdata_1_i(rd1), .mem_rdata_2_i(rd2), .mem_rdata_3_i(rd3),
    .core_rst_n_o(core_rst_n), .core_en_o(core_en), .core_read_en_o(core_read_en),
    .core_clr_o(core_clr), .core_op_mode_o(core_op_mode), .core_bias_o(core_bias),
    .dma_channel_0_o(dma0), .dma_channel_1_o(dma1), .dma_channel_2_o(dma2), .dma_channel_3_o(dma3),
    .core_done_i(core_done), .core_result_i(core_result), .core_pre_act_i(core_pre_act),
    .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready)
  );
  function automatic logic [63:0] pat(input int a, input int x);
    return {8'hA0 + 8'(x), 24'h0, 32'(a)};
  endfunction
  always @(posedge clk) if (mem_rd_en) begin
    rd0 <= pat(int'(mem_addr), 0);
    rd1 <= pat(int'(mem_addr), 1);
    rd2 <= pat(int'(mem_addr), 2);
    rd3 <= pat(int'(mem_addr), 3);
  end
  always @(posedge clk) ccnt <= !core_rst_n ? 5'd0 : (core_en && ccnt != 5'd31) ? ccnt + 5'd1 : ccnt;
  assign core_done = !stall && ccnt >= 5'd12 && ccnt < 5'd15;
  assign core_result = core_op_mode ? var_r : mu_r;
  assign core_pre_act = core_op_mode ? var_p : mu_p;
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst_n) begin
      pa1 = -1;
      pa2 = -1;
    end else begin
      if (out_valid && out_ready) begin
        rec_cnt++;
        e_rec = exp_q.size() != 0 ? exp_q.pop_front() : 48'hDEAD_DEAD_DEAD;
        chk("record", out_data, e_rec);
      end
      if (job_done) jd_cnt++;
      if (mem_rd_en) begin
        addr_log.push_back(int'(mem_addr));
        bias_log.push_back(core_bias);
      end
      if (pa2 >= 0) begin
        chk("dma0", dma0, pat(pa2, 0));
        chk("dma3", dma3, pat(pa2, 3));
      end
      pa2 = pa1;
      pa1 = mem_rd_en ? int'(mem_addr) : -1;
    end
  end
  task automatic do_start(input int n);
    @(negedge clk);
    start = 1;
    num_vectors = 16'(n);
    @(negedge clk);
    start = 0;
  endtask
  task automatic wait_done(input string nm, input int maxc, output int cyc);
    cyc = 0;
    while (!job_done && cyc < maxc) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, "_job_done"}, 64'(job_done), 64'd1);
    chk({nm, "_timeout_err"}, 64'(timeout_err), 64'(nm == "t4"));
    @(negedge clk);
  endtask
  task automatic chk_idle(input string nm);
    chk({nm, "_busy"}, 64'(busy), 0);
    chk({nm, "_rd_en"}, 64'(mem_rd_en), 0);
    chk({nm, "_addr"}, 64'(mem_addr), 0);
    chk({nm, "_core_rst_n"}, 64'(core_rst_n), 0);
    chk({nm, "_core_clr"}, 64'(core_clr), 1);
    chk({nm, "_core_en"}, 64'({core_en, core_read_en, core_op_mode}), 0);
    chk({nm, "_bias"}, 64'(core_bias), 0);
    chk({nm, "_out"}, 64'({out_valid, out_data}), 0);
    chk({nm, "_dma"}, dma0 | dma3, 0);
  endtask
  initial begin
    int c, jd0, rc;
    logic stable;
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int c, jd0, rc;
    logic stable;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    chk("reset_job_done", 64'({job_done, timeout_err}), 0);
    rst_n = 1;
    @(negedge clk);
    mu_r = 16'h0100; mu_p = 16'h1111; var_r = 16'h0020; var_p = 16'h2222;
    addr_log.delete(); bias_log.delete();
    exp_q.push_back(48'h0120_1111_2222);
    do_start(1);
    wait_done("t1", 200, c);
    chk("t1_nreads", addr_log.size(), 16);
    for (int i = 0; i < addr_log.size() && i < 16; i++) begin
      chk("t1_addr", addr_log[i], i % 8);
      chk("t1_bias", bias_log[i], i < 8 ? 16'h0018 : 16'hFFFF);
    end
    chk("t1_pending", exp_q.size(), 0);
    chk("t1_jd_cnt", jd_cnt, 1);
    chk("t1_busy", 64'(busy), 0);
    addr_log.delete(); bias_log.delete();
    repeat (3) exp_q.push_back(48'h0120_1111_2222);
    do_start(3);
    wait_done("t2", 600, c);
    chk("t2_nreads", addr_log.size(), 48);
    for (int v = 0; v < 3; v++)
      for (int p = 0; p < 2; p++)
        for (int b = 0; b < 8; b++)
          if (addr_log.size() == 48) chk("t2_addr", addr_log[v*16 + p*8 + b], v*8 + b);
    chk("t2_pending", exp_q.size(), 0);
    chk("t2_jd_cnt", jd_cnt, 2);
    out_ready = 0;
    exp_q.push_back(48'h0120_1111_2222);
    do_start(1);
    c = 0;
    while (!out_valid && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("t3_valid", 64'(out_valid), 1);
    held = out_data;
    stable = 1;
    repeat (20) begin
      @(negedge clk);
      if (!out_valid || out_data !== held || core_clr || mem_rd_en) stable = 0;
    end
    chk("t3_held", 64'(stable), 1);
    chk("t3_pending_held", exp_q.size(), 1);
    out_ready = 1;
    wait_done("t3", 10, c);
    chk("t3_pending", exp_q.size(), 0);
    stall = 1;
    do_start(1);
    wait_done("t4", TIMEOUT + 100, c);
    chk("t4_latency_ok", 64'(c >= TIMEOUT && c <= TIMEOUT + 20), 1);
    chk_idle("t4");
    chk("t4_err_sticky", 64'(timeout_err), 1);
    stall = 0;
    jd0 = jd_cnt; rc = rec_cnt;
    do_start(0);
    chk("t7_busy", 64'(busy), 0);
    wait_done("t7", 2, c);
    repeat (3) @(negedge clk);
    chk("t7_jd_cnt", jd_cnt, jd0 + 1);
    chk("t7_no_record", rec_cnt, rc);
    mu_r = 16'hFFF0; mu_p = 16'hAAAA; var_r = 16'h0020; var_p = 16'h5555;
    exp_q.push_back(48'h0010_AAAA_5555);
    do_start(1);
    wait_done("t5", 200, c);
    chk("t5_pending", exp_q.size(), 0);
    exp_q.push_back(48'h0010_AAAA_5555);
    do_start(2);
    c = 0;
    while (!(mem_rd_en && mem_addr == 19'd8) && c < 300) begin
      @(negedge clk);
      c++;
    end
    chk("t6_reached_vec1", 64'(mem_rd_en && mem_addr == 19'd8), 1);
    jd0 = jd_cnt; rc = rec_cnt;
    #1 rst_n = 0;
    #1 chk_idle("t6");
    repeat (5) @(negedge clk);
    rst_n = 1;
    repeat (30) @(negedge clk);
    chk("t6_no_job_done", jd_cnt, jd0);
    chk("t6_no_record", rec_cnt, rc);
    chk("t6_pending", exp_q.size(), 0);
    chk("t6_busy", 64'(busy), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
